// File: rtl/prescaled_updown_counter_pkg.sv
// Shared constants and helpers for the prescaled up/down counter.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Bound the counter heads toward: 0 when counting down, all-ones when counting up.
  function automatic logic [31:0] term_val(input logic dir, input int unsigned width);
    logic [31:0] ones;
    ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    return (dir == DIR_UP) ? ones : 32'h0;
  endfunction

  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/prescaled_updown_counter_if.sv
// Control/status bundle of the prescaled up/down counter; pre is a debug view of the prescaler.
interface prescaled_updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DIV   = 50000000
);
  localparam int PRE_W = pre_width(DIV);

  logic             en;
  logic             dir;
  logic             wrap_en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             tick;
  logic [WIDTH-1:0] y;
  logic             tc;
  logic             halted;
  logic [PRE_W-1:0] pre;

  // No valid/ready handshake: load is a single-cycle strobe sampled at every posedge,
  // and all other inputs are levels sampled at the edge that ends the current cycle.
  modport master (
    output en, dir, wrap_en, load, load_val,
    input  tick, y, tc, halted, pre
  );

  modport slave (
    input  en, dir, wrap_en, load, load_val,
    output tick, y, tc, halted, pre
  );

endinterface

// File: rtl/prescaled_updown_counter_tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and strobes tick in the last one.
module tick_gen
  import counter_pkg::*;
#(
  parameter int DIV = 50000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  output logic                      tick,
  output logic [pre_width(DIV)-1:0] pre
);
  localparam int PRE_W = pre_width(DIV);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;

  assign tick = en && (pre_q == LAST);
  assign pre  = pre_q;

  // en=0 freezes pre rather than clearing it, so a paused period resumes where it stopped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Up/down counter stepped by an internal prescaler; wraps or saturates at the bounds.
module prescaled_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter int               DIV   = 50000000,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic clk,
  input  logic rst,
  prescaled_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] y_q;
  logic             tc_q;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] step_val;
  logic             at_term;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (tick),
    .pre  (bus.pre)
  );

  assign term     = WIDTH'(term_val(bus.dir, WIDTH));
  assign at_term  = (y_q == term);
  // Modulo arithmetic makes the plain step also the wrap value at the bound.
  assign step_val = (bus.dir == DIR_UP) ? y_q + ONE : y_q - ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q  <= INIT;
      tc_q <= 1'b0;
    end else if (bus.load) begin
      y_q  <= bus.load_val;
      tc_q <= 1'b0;
    end else if (tick) begin
      if (!at_term) begin
        y_q  <= step_val;
        tc_q <= !bus.wrap_en && (step_val == term);
      end else if (bus.wrap_en) begin
        y_q  <= step_val;
        tc_q <= 1'b1;
      end else begin
        tc_q <= 1'b0;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign bus.tick   = tick;
  assign bus.y      = y_q;
  assign bus.tc     = tc_q;
  assign bus.halted = !bus.wrap_en && at_term;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter: directed scenarios, randomized run vs. a behavioural model,
// and a DIV=1/WIDTH=1 instance.
module tb_prescaled_updown_counter;

  localparam int W    = 3;
  localparam int D    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk;
  logic rst_a;
  logic rst_b;

  int tests;
  int fails;

  prescaled_updown_counter_if #(.WIDTH(W), .DIV(D)) bus_a ();
  prescaled_updown_counter_if #(.WIDTH(1), .DIV(1)) bus_b ();

  prescaled_updown_counter #(.WIDTH(W), .DIV(D), .INIT(3'd7)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  prescaled_updown_counter #(.WIDTH(1), .DIV(1), .INIT(1'b1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers: inputs change 1 time unit after the posedge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic dir, input logic wrap_en,
                         input logic load, input logic [W-1:0] load_val);
    bus_a.en       = en;
    bus_a.dir      = dir;
    bus_a.wrap_en  = wrap_en;
    bus_a.load     = load;
    bus_a.load_val = load_val;
  endtask

  // Behavioural model of instance a: counts of enabled cycles and integer arithmetic.
  int m_pre;
  int m_y;
  int m_tc;
  bit m_valid;

  always @(posedge clk) begin
    int bound;
    bound = bus_a.dir ? MAXV : 0;
    if (rst_a) begin
      m_pre   = 0;
      m_y     = MAXV;
      m_tc    = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_tc = 0;
      if (bus_a.load) begin
        m_y   = int'(bus_a.load_val);
        m_pre = 0;
      end else if (bus_a.en) begin
        if (m_pre == D - 1) begin
          m_pre = 0;
          if (m_y != bound) begin
            m_y  = bus_a.dir ? m_y + 1 : m_y - 1;
            m_tc = (!bus_a.wrap_en && m_y == bound) ? 1 : 0;
          end else if (bus_a.wrap_en) begin
            m_y  = bus_a.dir ? 0 : MAXV;
            m_tc = 1;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  end

  // Scoreboard compare: every negedge once the model has seen a reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("y", int'(bus_a.y), m_y);
      check("tc", int'(bus_a.tc), m_tc);
      check("pre", int'(bus_a.pre), m_pre);
      check("tick", int'(bus_a.tick), (bus_a.en && m_pre == D - 1) ? 1 : 0);
      check("halted", int'(bus_a.halted),
            (!bus_a.wrap_en && m_y == (bus_a.dir ? MAXV : 0)) ? 1 : 0);
    end
  end

  logic [W-1:0] exp_q[$];

  initial begin
    tests   = 0;
    fails   = 0;
    m_valid = 1'b0;
    m_pre   = 0;
    m_y     = 0;
    m_tc    = 0;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    drive_a(1'b0, 1'b0, 1'b1, 1'b0, '0);
    bus_b.en       = 1'b0;
    bus_b.dir      = 1'b1;
    bus_b.wrap_en  = 1'b1;
    bus_b.load     = 1'b0;
    bus_b.load_val = 1'b0;

    step(2);
    check("reset_y", int'(bus_a.y), 7);
    check("reset_tc", int'(bus_a.tc), 0);
    check("reset_pre", int'(bus_a.pre), 0);

    // 1: wrapping count down from 7
    rst_a = 1'b0;
    drive_a(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(3);
    check("s1_first_tick", int'(bus_a.tick), 1);
    step(1);
    check("s1_first_y", int'(bus_a.y), 6);
    exp_q = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    for (int k = 0; k < 7; k++) begin
      step(4);
      check("s1_seq_y", int'(bus_a.y), int'(exp_q[k]));
      check("s1_seq_tc", int'(bus_a.tc), (k == 6) ? 1 : 0);
    end

    // 2: saturating count up from a load of 5
    drive_a(1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
    step(1);
    check("s2_load_y", int'(bus_a.y), 5);
    bus_a.load = 1'b0;
    step(4);
    check("s2_y6", int'(bus_a.y), 6);
    check("s2_tc6", int'(bus_a.tc), 0);
    step(4);
    check("s2_y7", int'(bus_a.y), 7);
    check("s2_tc7", int'(bus_a.tc), 1);
    check("s2_halted", int'(bus_a.halted), 1);
    step(4);
    check("s2_hold_y", int'(bus_a.y), 7);
    check("s2_hold_tc", int'(bus_a.tc), 0);
    bus_a.dir = 1'b0;
    #1;
    check("s2_unhalt", int'(bus_a.halted), 0);
    step(4);
    check("s2_away_y", int'(bus_a.y), 6);

    // 3: load coinciding with tick
    step(3);
    check("s3_tick", int'(bus_a.tick), 1);
    bus_a.load     = 1'b1;
    bus_a.load_val = 3'd2;
    step(1);
    bus_a.load = 1'b0;
    check("s3_y", int'(bus_a.y), 2);
    check("s3_pre", int'(bus_a.pre), 0);
    check("s3_tc", int'(bus_a.tc), 0);
    step(4);
    check("s3_next_y", int'(bus_a.y), 1);

    // 4: pause the prescaler at pre==2
    step(2);
    check("s4_pre", int'(bus_a.pre), 2);
    bus_a.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("s4_pre_hold", int'(bus_a.pre), 2);
      check("s4_y_hold", int'(bus_a.y), 1);
      check("s4_tick_low", int'(bus_a.tick), 0);
    end
    bus_a.en = 1'b1;
    step(1);
    check("s4_resume_tick", int'(bus_a.tick), 1);
    step(1);
    check("s4_resume_y", int'(bus_a.y), 0);
    check("s4_resume_tc", int'(bus_a.tc), 1);

    // 5: reset mid-period, then a reset glitch between edges
    bus_a.load     = 1'b1;
    bus_a.load_val = 3'd3;
    step(1);
    bus_a.load = 1'b0;
    step(2);
    check("s5_pre", int'(bus_a.pre), 2);
    check("s5_y", int'(bus_a.y), 3);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    check("s5_rst_y", int'(bus_a.y), 7);
    check("s5_rst_pre", int'(bus_a.pre), 0);
    check("s5_rst_tc", int'(bus_a.tc), 0);
    #2 rst_a = 1'b1;
    #1 rst_a = 1'b0;
    step(1);
    check("s5_glitch_pre", int'(bus_a.pre), 1);
    check("s5_glitch_y", int'(bus_a.y), 7);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst_a = ($urandom_range(0, 199) == 0);
      bus_a.en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus_a.dir = ~bus_a.dir;
      if ($urandom_range(0, 31) == 0) bus_a.wrap_en = ~bus_a.wrap_en;
      bus_a.load     = ($urandom_range(0, 29) == 0);
      bus_a.load_val = W'($urandom_range(0, MAXV));
      step(1);
    end
    rst_a = 1'b0;

    // 6: DIV=1, WIDTH=1 toggling counter
    bus_b.en = 1'b1;
    step(1);
    check("s6_reset_y", int'(bus_b.y), 1);
    check("s6_tick", int'(bus_b.tick), 1);
    rst_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("s6_y", int'(bus_b.y), (1 + k) % 2);
      check("s6_tc", int'(bus_b.tc), ((1 + k) % 2 == 0) ? 1 : 0);
      check("s6_halted", int'(bus_b.halted), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
